nrf24_rx_ctrl: RTL and testbench

- Receive-side controller for an nRF24L01+ radio; mirror of the camera-board transmitter.
- Sets the radio up as a primary receiver and waits for the IRQ line.
- On each interrupt, reads the payload over SPI and clears the RX_DR flag.
- Presents received bytes plus a latched capture flag (cap_val) to the display/ABS logic on the receiving board.

---
 rtl/nrf24_rx_ctrl_if.sv | 14 +
 rtl/nrf24_rx_ctrl.sv | 264 ++++++++++++++++++++++++++
 tb/tb_nrf24_rx_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/nrf24_rx_ctrl_if.sv
// Radio-side bus of the nRF24L01+ receive controller: SPI lines plus CE and IRQ.
interface nrf24_rx_ctrl_if;
    logic nrf_sclk;
    logic nrf_mosi;
    logic nrf_miso;
    logic nrf_csn;
    logic nrf_ce;
    logic nrf_irq_n;

    modport master (output nrf_sclk, nrf_mosi, nrf_csn, nrf_ce,
                    input  nrf_miso, nrf_irq_n);
    modport slave  (input  nrf_sclk, nrf_mosi, nrf_csn, nrf_ce,
                    output nrf_miso, nrf_irq_n);
endinterface

// File: rtl/nrf24_rx_ctrl.sv
// nRF24L01+ primary-receiver controller: configures the radio, then on each IRQ
// reads one static payload over SPI mode 0 and clears RX_DR.
module nrf24_rx_ctrl #(
    parameter int unsigned SPI_HALF      = 50,
    parameter int unsigned PWRUP_DELAY   = 150_000,
    parameter int unsigned PAYLOAD_BYTES = 1,
    parameter logic [7:0]  RF_CH         = 8'd2
) (
    input  logic                       clk,
    input  logic                       reset,
    nrf24_rx_ctrl_if.master            nrf,
    output logic [8*PAYLOAD_BYTES-1:0] rx_data,
    output logic                       rx_valid,
    output logic                       cap_val,
    output logic                       cfg_done,
    output logic [15:0]                rx_count
);
    localparam int unsigned DW = $clog2(PWRUP_DELAY + 1);
    localparam int unsigned CW = $clog2(2 * SPI_HALF + 1);

    typedef enum logic [2:0] {
        PWR_WAIT, CFG, FLUSH, FLUSH_WAIT, LISTEN, RD_PAYLOAD, CLR, CLR_GAP
    } state_t;
    typedef enum logic [2:0] {
        SPI_IDLE, SPI_LEAD, SPI_HIGH, SPI_LOW, SPI_TRAIL, SPI_GAP
    } spi_t;

    state_t state, state_n;
    spi_t   sp, sp_n;
    logic [DW-1:0] dly, dly_n;
    logic [2:0]    cfg_idx, cfg_idx_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n, byte_idx, byte_n, tx_idx, last_byte;
    logic [7:0]    tx_sr, tx_sr_n, tx_byte, cfg_addr, cfg_val;
    logic [6:0]    rx_sr, rx_sr_n;
    logic [8*PAYLOAD_BYTES-1:0] payload, payload_n;
    logic sclk, sclk_n, csn, csn_n;
    logic sp_start, sp_done, load_rx, go_listen, listen;
    logic [1:0] irq_sync, miso_sync;
    logic irq_s, miso_s;

    assign irq_s        = irq_sync[1];
    assign miso_s       = miso_sync[1];
    assign nrf.nrf_sclk = sclk;
    assign nrf.nrf_mosi = tx_sr[7];
    assign nrf.nrf_csn  = csn;
    assign nrf.nrf_ce   = listen;
    assign cfg_done     = listen;

    always_comb begin
        cfg_addr = 8'h00;
        cfg_val  = 8'h00;
        case (cfg_idx)
            3'd0: begin cfg_addr = 8'h01; cfg_val = 8'h00;              end
            3'd1: begin cfg_addr = 8'h02; cfg_val = 8'h01;              end
            3'd2: begin cfg_addr = 8'h03; cfg_val = 8'h03;              end
            3'd3: begin cfg_addr = 8'h05; cfg_val = RF_CH;              end
            3'd4: begin cfg_addr = 8'h06; cfg_val = 8'h06;              end
            3'd5: begin cfg_addr = 8'h11; cfg_val = 8'(PAYLOAD_BYTES); end
            3'd6: begin cfg_addr = 8'h07; cfg_val = 8'h70;              end
            default: begin cfg_addr = 8'h00; cfg_val = 8'h0F;           end
        endcase
    end

    // Byte to load: index 0 at transaction start, otherwise the byte after the current one.
    always_comb begin
        tx_idx    = (sp == SPI_IDLE) ? 3'd0 : byte_idx + 3'd1;
        tx_byte   = 8'h00;
        last_byte = 3'd1;
        case (state)
            CFG:        tx_byte = (tx_idx == 3'd0) ? (8'h20 | cfg_addr) : cfg_val;
            FLUSH:      begin tx_byte = 8'hE2; last_byte = 3'd0; end
            RD_PAYLOAD: begin
                tx_byte   = (tx_idx == 3'd0) ? 8'h61 : 8'hFF;
                last_byte = 3'(PAYLOAD_BYTES);
            end
            CLR:        tx_byte = (tx_idx == 3'd0) ? 8'h27 : 8'h40;
            default:    ;
        endcase
    end

    always_comb begin
        state_n   = state;
        dly_n     = dly;
        cfg_idx_n = cfg_idx;
        sp_start  = 1'b0;
        load_rx   = 1'b0;
        go_listen = 1'b0;
        case (state)
            PWR_WAIT, FLUSH_WAIT: begin
                if (dly == DW'(PWRUP_DELAY - 1)) begin
                    dly_n     = '0;
                    state_n   = (state == PWR_WAIT) ? CFG : LISTEN;
                    go_listen = (state == FLUSH_WAIT);
                end else begin
                    dly_n = dly + 1'b1;
                end
            end
            CFG: begin
                sp_start = (sp == SPI_IDLE);
                if (sp_done) begin
                    cfg_idx_n = cfg_idx + 3'd1;
                    if (cfg_idx == 3'd7) state_n = FLUSH;
                end
            end
            FLUSH: begin
                sp_start = (sp == SPI_IDLE);
                if (sp_done) begin
                    state_n = FLUSH_WAIT;
                    dly_n   = '0;
                end
            end
            LISTEN:     if (!irq_s) state_n = RD_PAYLOAD;
            RD_PAYLOAD: begin
                sp_start = (sp == SPI_IDLE);
                if (sp_done) state_n = CLR;
            end
            CLR: begin
                sp_start = (sp == SPI_IDLE);
                if (sp_done) begin
                    load_rx = 1'b1;
                    state_n = CLR_GAP;
                end
            end
            default: if (sp == SPI_IDLE) state_n = irq_s ? LISTEN : RD_PAYLOAD;
        endcase
    end

    always_comb begin
        sp_n      = sp;
        cnt_n     = cnt;
        bit_n     = bit_idx;
        byte_n    = byte_idx;
        tx_sr_n   = tx_sr;
        rx_sr_n   = rx_sr;
        payload_n = payload;
        sclk_n    = sclk;
        csn_n     = csn;
        sp_done   = 1'b0;
        case (sp)
            SPI_IDLE: if (sp_start) begin
                sp_n    = SPI_LEAD;
                csn_n   = 1'b0;
                cnt_n   = '0;
                bit_n   = '0;
                byte_n  = '0;
                tx_sr_n = tx_byte;
            end
            SPI_LEAD, SPI_LOW: begin
                if (cnt == CW'(SPI_HALF - 1)) begin
                    cnt_n  = '0;
                    sclk_n = 1'b1;
                    sp_n   = SPI_HIGH;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SPI_HIGH: begin
                // MISO taken two clocks after the rise so the synchronizer shows the value at the edge.
                if (cnt == CW'(1)) begin
                    rx_sr_n = {rx_sr[5:0], miso_s};
                    for (int unsigned i = 0; i < PAYLOAD_BYTES; i++)
                        if (bit_idx == 3'd7 && byte_idx == 3'(i + 1))
                            payload_n[8*i +: 8] = {rx_sr, miso_s};
                end
                if (cnt == CW'(SPI_HALF - 1)) begin
                    cnt_n  = '0;
                    sclk_n = 1'b0;
                    sp_n   = SPI_LOW;
                    if (bit_idx != 3'd7) begin
                        bit_n   = bit_idx + 3'd1;
                        tx_sr_n = {tx_sr[6:0], 1'b0};
                    end else if (byte_idx != last_byte) begin
                        bit_n   = '0;
                        byte_n  = byte_idx + 3'd1;
                        tx_sr_n = tx_byte;
                    end else begin
                        tx_sr_n = '0;
                        sp_n    = SPI_TRAIL;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SPI_TRAIL: begin
                if (cnt == CW'(SPI_HALF - 1)) begin
                    cnt_n   = '0;
                    csn_n   = 1'b1;
                    sp_done = 1'b1;
                    sp_n    = SPI_GAP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SPI_GAP: begin
                if (cnt == CW'(2 * SPI_HALF - 1)) begin
                    cnt_n = '0;
                    sp_n  = SPI_IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: sp_n = SPI_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= PWR_WAIT;
            dly     <= '0;
            cfg_idx <= '0;
        end else begin
            state   <= state_n;
            dly     <= dly_n;
            cfg_idx <= cfg_idx_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sp       <= SPI_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            byte_idx <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            payload  <= '0;
            sclk     <= 1'b0;
            csn      <= 1'b1;
        end else begin
            sp       <= sp_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            byte_idx <= byte_n;
            tx_sr    <= tx_sr_n;
            rx_sr    <= rx_sr_n;
            payload  <= payload_n;
            sclk     <= sclk_n;
            csn      <= csn_n;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_sync  <= 2'b11;
            miso_sync <= 2'b00;
            listen    <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            cap_val   <= 1'b0;
            rx_count  <= '0;
        end else begin
            irq_sync  <= {irq_sync[0], nrf.nrf_irq_n};
            miso_sync <= {miso_sync[0], nrf.nrf_miso};
            rx_valid  <= load_rx;
            if (go_listen) listen <= 1'b1;
            if (load_rx) begin
                rx_data  <= payload;
                cap_val  <= payload[0];
                rx_count <= rx_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_nrf24_rx_ctrl.sv
// Directed bench for nrf24_rx_ctrl with a behavioural nRF24L01+ SPI slave model.
module tb_nrf24_rx_ctrl;
    localparam int unsigned SPI_HALF      = 2;
    localparam int unsigned PWRUP_DELAY   = 100;
    localparam int unsigned PAYLOAD_BYTES = 1;
    localparam logic [7:0]  RF_CH         = 8'd2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_valid, cap_val, cfg_done;
    logic [15:0] rx_count;

    nrf24_rx_ctrl_if nrf();

    nrf24_rx_ctrl #(
        .SPI_HALF(SPI_HALF),
        .PWRUP_DELAY(PWRUP_DELAY),
        .PAYLOAD_BYTES(PAYLOAD_BYTES),
        .RF_CH(RF_CH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .nrf(nrf),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .cap_val(cap_val),
        .cfg_done(cfg_done),
        .rx_count(rx_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] cfg_exp [17] = '{8'h21, 8'h00, 8'h22, 8'h01, 8'h23, 8'h03, 8'h25, 8'h02,
                                 8'h26, 8'h06, 8'h31, 8'h01, 8'h27, 8'h70, 8'h20, 8'h0F, 8'hE2};
    logic [7:0] rd_exp [4] = '{8'h61, 8'hFF, 8'h27, 8'h40};

    // Payload FIFO inside the radio: the bench pushes, the model pops on each STATUS=40 write.
    logic [7:0] pay [16];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign nrf.nrf_irq_n = (wr_ptr == rd_ptr);

    logic [7:0]  log_q [$];
    logic [7:0]  txn [$];
    logic [7:0]  sh = '0;
    logic [15:0] miso_sr = '0;
    logic csn_p = 1'b1, sck_p = 1'b0, mosi_p = 1'b0, v_p = 1'b0, cfg_p = 1'b0;
    bit   lat_pending = 1'b0;
    int cyc = 0, bitn = 0, viol = 0, min_gap = 1000000, rise_cyc = -1000, last_gap = 0;
    int cfg_rise_cyc = 0, cfg_delay = 0, listen_lat = -1, v_hi = 0, v_rise = 0;

    always @(negedge clk) begin
        cyc++;
        if (nrf.nrf_csn && nrf.nrf_sclk) viol++;
        if (nrf.nrf_csn && csn_p && nrf.nrf_sclk != sck_p) viol++;
        if (csn_p && !nrf.nrf_csn) begin
            last_gap = cyc - rise_cyc;
            if (last_gap < min_gap) min_gap = last_gap;
            bitn = 0;
            txn.delete();
            miso_sr = {8'h0E, (wr_ptr != rd_ptr) ? pay[rd_ptr % 16] : 8'h00};
            if (lat_pending) begin
                listen_lat  = cyc - cfg_rise_cyc;
                lat_pending = 1'b0;
            end
        end
        if (!nrf.nrf_csn && !sck_p && nrf.nrf_sclk) begin
            if (nrf.nrf_mosi != mosi_p) viol++;
            sh = {sh[6:0], nrf.nrf_mosi};
            bitn++;
            if (bitn == 8) begin
                log_q.push_back(sh);
                txn.push_back(sh);
                bitn = 0;
            end
        end
        if (!nrf.nrf_csn && sck_p && !nrf.nrf_sclk) miso_sr = {miso_sr[14:0], 1'b0};
        if (!csn_p && nrf.nrf_csn) begin
            rise_cyc = cyc;
            if (txn.size() == 2 && txn[0] == 8'h27 && txn[1] == 8'h40 && wr_ptr != rd_ptr)
                rd_ptr++;
        end
        nrf.nrf_miso = miso_sr[15];
        if (cfg_done && !cfg_p) begin
            cfg_delay    = cyc - rise_cyc;
            cfg_rise_cyc = cyc;
            lat_pending  = 1'b1;
        end
        if (rx_valid) v_hi++;
        if (rx_valid && !v_p) v_rise++;
        csn_p  = nrf.nrf_csn;
        sck_p  = nrf.nrf_sclk;
        mosi_p = nrf.nrf_mosi;
        v_p    = rx_valid;
        cfg_p  = cfg_done;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] byte_at(input int idx);
        return (idx < log_q.size()) ? {24'h0, log_q[idx]} : 32'hDEAD;
    endfunction

    task automatic expect_cfg(input int base);
        int n;
        n = 0;
        while (!cfg_done && n < 5000) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        #1;
        check("cfg_done_up", cfg_done, 1);
        check("cfg_len", log_q.size() - base, 17);
        for (int i = 0; i < 17; i++) check("cfg_byte", byte_at(base + i), cfg_exp[i]);
        check("cfg_delay", cfg_delay, PWRUP_DELAY);
        check("ce_up", nrf.nrf_ce, 1);
    endtask

    task automatic wait_count(input logic [15:0] target, input int budget);
        int n;
        n = 0;
        while (rx_count != target && n < budget) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int base, vr0, vh0, n;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_csn", nrf.nrf_csn, 1);
        check("rst_sclk", nrf.nrf_sclk, 0);
        check("rst_mosi", nrf.nrf_mosi, 0);
        check("rst_ce", nrf.nrf_ce, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_cap_val", cap_val, 0);
        check("rst_cfg_done", cfg_done, 0);
        check("rst_rx_count", rx_count, 0);
        @(negedge clk);
        reset = 1'b0;
        base = log_q.size();
        expect_cfg(base);

        // single packet
        base = log_q.size(); vr0 = v_rise; vh0 = v_hi;
        pay[wr_ptr % 16] = 8'h01; wr_ptr++;
        wait_count(16'd1, 2000);
        check("sp_count", rx_count, 1);
        check("sp_data", rx_data, 8'h01);
        check("sp_cap", cap_val, 1);
        repeat (50) @(negedge clk);
        check("sp_len", log_q.size() - base, 4);
        for (int i = 0; i < 4; i++) check("sp_byte", byte_at(base + i), rd_exp[i]);
        check("sp_pulses", v_rise - vr0, 1);
        check("sp_width", v_hi - vh0, 1);
        check("sp_irq_rel", nrf.nrf_irq_n, 1);

        // back-to-back FIFO
        base = log_q.size(); vr0 = v_rise; vh0 = v_hi;
        pay[wr_ptr % 16] = 8'h01; wr_ptr++;
        pay[wr_ptr % 16] = 8'h00; wr_ptr++;
        n = 0;
        while (log_q.size() < base + 5 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check("b2b_gap", last_gap, 6);
        wait_count(16'd3, 2000);
        repeat (50) @(negedge clk);
        check("b2b_count", rx_count, 3);
        check("b2b_data", rx_data, 8'h00);
        check("b2b_cap", cap_val, 0);
        check("b2b_pulses", v_rise - vr0, 2);
        check("b2b_width", v_hi - vh0, 2);
        check("b2b_len", log_q.size() - base, 8);
        for (int i = 0; i < 8; i++) check("b2b_byte", byte_at(base + i), rd_exp[i % 4]);
        check("b2b_irq_rel", nrf.nrf_irq_n, 1);

        // reset during the second byte of a payload read
        base = log_q.size();
        pay[wr_ptr % 16] = 8'h01; wr_ptr++;
        n = 0;
        while (!(log_q.size() == base + 1 && bitn >= 2 && !nrf.nrf_csn) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check("mr_in_read", (log_q.size() == base + 1 && bitn >= 2 && !nrf.nrf_csn), 1);
        #1 reset = 1'b1;
        #1;
        check("mr_csn", nrf.nrf_csn, 1);
        check("mr_sclk", nrf.nrf_sclk, 0);
        check("mr_ce", nrf.nrf_ce, 0);
        check("mr_cfg_done", cfg_done, 0);
        check("mr_count", rx_count, 0);
        check("mr_valid", rx_valid, 0);
        wr_ptr = rd_ptr;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        base = log_q.size();

        // early IRQ while powering up
        pay[wr_ptr % 16] = 8'h01; wr_ptr++;
        expect_cfg(base);
        repeat (5) @(negedge clk);
        check("early_lat", listen_lat, 2);
        wait_count(16'd1, 2000);
        repeat (20) @(negedge clk);
        check("early_count", rx_count, 1);
        check("early_cap", cap_val, 1);
        for (int i = 0; i < 4; i++) check("early_byte", byte_at(base + 17 + i), rd_exp[i]);

        check("spi_viol", viol, 0);
        check("csn_gap_ge4", (min_gap >= 4), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
